// File: rtl/mem_port_arbiter_if.sv
// Main-memory block port shared by the I-cache and D-cache refill/writeback paths.
interface mem_port_arbiter_if #(
  parameter int BLOCK_W = 256,
  parameter int ADDR_W  = 32
);
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block memory port between I-cache refills and
// D-cache writeback/refills, with a per-request timeout and a pipeline freeze.
module mem_port_arbiter #(
  parameter int BLOCK_W     = 256,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_done,
  output logic [BLOCK_W-1:0] i_rdata,
  input  logic               d_rd_req,
  input  logic               d_wr_req,
  input  logic [ADDR_W-1:0]  d_rd_addr,
  input  logic [ADDR_W-1:0]  d_wr_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_done,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               FREEZE,
  output logic               mem_err,
  mem_port_arbiter_if.master mem
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] I_RD = 3'd1;
  localparam logic [2:0] D_WB = 3'd2;
  localparam logic [2:0] D_RD = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int              TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TLIM      = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(32'h1F);

  logic [2:0]    state;
  logic          last_gnt;
  logic [TW-1:0] timer;
  logic          d_pend;

  assign d_pend = d_rd_req | d_wr_req;
  assign FREEZE = (state != IDLE) | i_req | d_pend;

  // In a request state a cleared mem_req marks the one-cycle gap between a
  // dirty-miss writeback and its refill; the refill request is raised after it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= IDLE;
      last_gnt      <= GNT_D;
      timer         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      mem_err       <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req && (!d_pend || last_gnt == GNT_D)) begin
            state        <= I_RD;
            last_gnt     <= GNT_I;
            timer        <= '0;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= i_addr & BLK_MASK;
          end else if (d_pend) begin
            last_gnt    <= GNT_D;
            timer       <= '0;
            mem.mem_req <= 1'b1;
            if (d_wr_req) begin
              state         <= D_WB;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= d_wr_addr & BLK_MASK;
              mem.mem_wdata <= d_wdata;
            end else begin
              state        <= D_RD;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= d_rd_addr & BLK_MASK;
            end
          end
        end
        I_RD, D_WB, D_RD: begin
          if (!mem.mem_req) begin
            mem.mem_req <= 1'b1;
            timer       <= '0;
          end else if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            timer       <= '0;
            if (state == I_RD) begin
              i_rdata <= mem.mem_rdata;
              i_done  <= 1'b1;
              state   <= RESP;
            end else if (state == D_RD) begin
              d_rdata <= mem.mem_rdata;
              d_done  <= 1'b1;
              state   <= RESP;
            end else if (d_rd_req) begin
              state        <= D_RD;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= d_rd_addr & BLK_MASK;
            end else begin
              d_done <= 1'b1;
              state  <= RESP;
            end
          end else if (timer == TLIM) begin
            mem.mem_req <= 1'b0;
            timer       <= '0;
            mem_err     <= 1'b1;
            state       <= RESP;
            if (state == I_RD) begin
              i_rdata <= '0;
              i_done  <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_done  <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
